// File: rtl/bomb_manager_if.sv
//----------------------------------------------------------------------------
// Module      : bomb_manager_if
// Description : Player-side request and map/status bus of the bomb manager.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface bomb_manager_if #(
    parameter int HMAXTILE = 9,
    parameter int VMAXTILE = 5
);
    localparam int NCELL = (HMAXTILE + 1) * (VMAXTILE + 1);

    logic             tick;
    logic             aPlace;
    logic [3:0]       aH;
    logic [3:0]       aV;
    logic             bPlace;
    logic [3:0]       bH;
    logic [3:0]       bV;
    logic [NCELL-1:0] bombMap;
    logic [NCELL-1:0] blastMap;
    logic [3:0]       aCount;
    logic [3:0]       bCount;
    logic             aHit;
    logic             bHit;
    logic             full;

    modport master (
        output tick, aPlace, aH, aV, bPlace, bH, bV,
        input  bombMap, blastMap, aCount, bCount, aHit, bHit, full
    );

    modport slave (
        input  tick, aPlace, aH, aV, bPlace, bH, bV,
        output bombMap, blastMap, aCount, bCount, aHit, bHit, full
    );
endinterface

`default_nettype wire

// File: rtl/bomb_manager.sv
//----------------------------------------------------------------------------
// Module      : bomb_manager
// Description : Owns all live bombs: placement, fuse/blast countdown, maps,
//               per-player counts and hit flags. BOMB_CHAIN_EN enables
//               chain detonation of fused bombs caught in a blast.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module bomb_manager #(
    parameter int HMAXTILE    = 9,
    parameter int VMAXTILE    = 5,
    parameter int NSLOT       = 4,
    parameter int MAXPER      = 2,
    parameter int FUSE_TICKS  = 3,
    parameter int BLAST_TICKS = 2,
    parameter int RADIUS      = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    bomb_manager_if.slave bus
);
    localparam int NCELL = (HMAXTILE + 1) * (VMAXTILE + 1);
    localparam int IDXW  = $clog2(NCELL);
    localparam int SW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FUSE  = 2'd1,
        BLAST = 2'd2
    } slot_state_e;

    slot_state_e state_q [NSLOT];
    slot_state_e state_d [NSLOT];
    logic        owner_q [NSLOT];   // 0 = player A, 1 = player B
    logic        owner_d [NSLOT];
    logic [3:0]  h_q     [NSLOT];
    logic [3:0]  h_d     [NSLOT];
    logic [3:0]  v_q     [NSLOT];
    logic [3:0]  v_d     [NSLOT];
    logic [2:0]  cnt_q   [NSLOT];
    logic [2:0]  cnt_d   [NSLOT];

    logic [NCELL-1:0] bomb_map;
    logic [NCELL-1:0] blast_map;
    logic [NSLOT-1:0] live;
    logic [NSLOT-1:0] chain_hit;
    logic [3:0]       a_cnt;
    logic [3:0]       b_cnt;
    logic             a_hit;
    logic             b_hit;
    logic             a_clash;
    logic             b_clash;
    logic             a_found;
    logic             b_found;
    logic             a_ok;
    logic             b_ok;
    logic [SW-1:0]    a_slot;
    logic [SW-1:0]    b_slot;

    // Wide intermediate arithmetic so v*(HMAXTILE+1) can never wrap.
    function automatic logic [IDXW-1:0] cell_idx(input logic [3:0] h, input logic [3:0] v);
        return IDXW'(int'(v) * (HMAXTILE + 1) + int'(h));
    endfunction

    function automatic logic in_range(input logic [3:0] h, input logic [3:0] v);
        return (int'(h) <= HMAXTILE) && (int'(v) <= VMAXTILE);
    endfunction

    always_comb begin
        bomb_map  = '0;
        blast_map = '0;
        live      = '0;
        a_cnt     = '0;
        b_cnt     = '0;
        for (int s = 0; s < NSLOT; s++) begin
            live[s] = (state_q[s] != IDLE);
            if (live[s] && !owner_q[s]) a_cnt = a_cnt + 4'd1;
            if (live[s] &&  owner_q[s]) b_cnt = b_cnt + 4'd1;
            if (state_q[s] == FUSE) bomb_map[cell_idx(h_q[s], v_q[s])] = 1'b1;
            if (state_q[s] == BLAST) begin
                // Each arm is clipped before the index is formed, so no row wrap.
                for (int d = 0; d <= RADIUS; d++) begin
                    if (int'(h_q[s]) >= d)
                        blast_map[cell_idx(h_q[s] - 4'(d), v_q[s])] = 1'b1;
                    if (int'(h_q[s]) + d <= HMAXTILE)
                        blast_map[cell_idx(h_q[s] + 4'(d), v_q[s])] = 1'b1;
                    if (int'(v_q[s]) >= d)
                        blast_map[cell_idx(h_q[s], v_q[s] - 4'(d))] = 1'b1;
                    if (int'(v_q[s]) + d <= VMAXTILE)
                        blast_map[cell_idx(h_q[s], v_q[s] + 4'(d))] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        a_hit = 1'b0;
        b_hit = 1'b0;
        if (in_range(bus.aH, bus.aV)) a_hit = blast_map[cell_idx(bus.aH, bus.aV)];
        if (in_range(bus.bH, bus.bV)) b_hit = blast_map[cell_idx(bus.bH, bus.bV)];
    end

    always_comb begin
        chain_hit = '0;
`ifdef BOMB_CHAIN_EN
        for (int s = 0; s < NSLOT; s++)
            chain_hit[s] = (state_q[s] == FUSE) && blast_map[cell_idx(h_q[s], v_q[s])];
`endif
    end

    // Placement arbitration: A is granted first, B sees A's grant.
    always_comb begin
        a_clash = 1'b0;
        b_clash = 1'b0;
        a_found = 1'b0;
        b_found = 1'b0;
        a_slot  = '0;
        b_slot  = '0;
        for (int s = 0; s < NSLOT; s++) begin
            if (live[s] && h_q[s] == bus.aH && v_q[s] == bus.aV) a_clash = 1'b1;
            if (live[s] && h_q[s] == bus.bH && v_q[s] == bus.bV) b_clash = 1'b1;
            if (!live[s] && !a_found) begin
                a_found = 1'b1;
                a_slot  = SW'(s);
            end
        end
        a_ok = bus.aPlace && in_range(bus.aH, bus.aV) && !a_clash
            && (int'(a_cnt) < MAXPER) && a_found;
        for (int s = 0; s < NSLOT; s++) begin
            if (!live[s] && !b_found && !(a_ok && a_slot == SW'(s))) begin
                b_found = 1'b1;
                b_slot  = SW'(s);
            end
        end
        b_ok = bus.bPlace && in_range(bus.bH, bus.bV) && !b_clash
            && !(a_ok && bus.aH == bus.bH && bus.aV == bus.bV)
            && (int'(b_cnt) < MAXPER) && b_found;
    end

    always_comb begin
        for (int s = 0; s < NSLOT; s++) begin
            state_d[s] = state_q[s];
            owner_d[s] = owner_q[s];
            h_d[s]     = h_q[s];
            v_d[s]     = v_q[s];
            cnt_d[s]   = cnt_q[s];
            case (state_q[s])
                FUSE: begin
                    if (chain_hit[s] || (bus.tick && cnt_q[s] <= 3'd1)) begin
                        state_d[s] = BLAST;
                        cnt_d[s]   = 3'(BLAST_TICKS);
                    end else if (bus.tick) begin
                        cnt_d[s] = cnt_q[s] - 3'd1;
                    end
                end
                BLAST: begin
                    if (bus.tick && cnt_q[s] <= 3'd1) begin
                        state_d[s] = IDLE;
                        cnt_d[s]   = 3'd0;
                    end else if (bus.tick) begin
                        cnt_d[s] = cnt_q[s] - 3'd1;
                    end
                end
                default: begin
                    if (a_ok && a_slot == SW'(s)) begin
                        state_d[s] = FUSE;
                        owner_d[s] = 1'b0;
                        h_d[s]     = bus.aH;
                        v_d[s]     = bus.aV;
                        cnt_d[s]   = 3'(FUSE_TICKS);
                    end else if (b_ok && b_slot == SW'(s)) begin
                        state_d[s] = FUSE;
                        owner_d[s] = 1'b1;
                        h_d[s]     = bus.bH;
                        v_d[s]     = bus.bV;
                        cnt_d[s]   = 3'(FUSE_TICKS);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NSLOT; s++) begin
                state_q[s] <= IDLE;
                owner_q[s] <= 1'b0;
                h_q[s]     <= 4'd0;
                v_q[s]     <= 4'd0;
                cnt_q[s]   <= 3'd0;
            end
        end else begin
            for (int s = 0; s < NSLOT; s++) begin
                state_q[s] <= state_d[s];
                owner_q[s] <= owner_d[s];
                h_q[s]     <= h_d[s];
                v_q[s]     <= v_d[s];
                cnt_q[s]   <= cnt_d[s];
            end
        end
    end

    assign bus.bombMap  = bomb_map;
    assign bus.blastMap = blast_map;
    assign bus.aCount   = a_cnt;
    assign bus.bCount   = b_cnt;
    assign bus.aHit     = a_hit;
    assign bus.bHit     = b_hit;
    assign bus.full     = &live;

endmodule

`default_nettype wire

// File: tb/tb_bomb_manager.sv
//----------------------------------------------------------------------------
// Module      : tb_bomb_manager
// Description : Directed bench for bomb_manager with a bomb-list reference
//               model; honours BOMB_CHAIN_EN when defined.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_bomb_manager;
    localparam int HMAX   = 9;
    localparam int VMAX   = 5;
    localparam int NSLOT  = 4;
    localparam int MAXPER = 2;
    localparam int FUSE   = 3;
    localparam int BLAST  = 2;
    localparam int RAD    = 1;
    localparam int NCELL  = 60;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bomb_manager_if #(.HMAXTILE(HMAX), .VMAXTILE(VMAX)) bus ();

    bomb_manager #(
        .HMAXTILE(HMAX), .VMAXTILE(VMAX), .NSLOT(NSLOT), .MAXPER(MAXPER),
        .FUSE_TICKS(FUSE), .BLAST_TICKS(BLAST), .RADIUS(RAD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // A bomb is just remaining lifetime in ticks: fuse while life > BLAST.
    typedef struct {
        int owner;
        int h;
        int v;
        int life;
    } bomb_t;

    bomb_t bombs[$];
    int    checks   = 0;
    int    failures = 0;
    bit    chk_en   = 1'b0;

    function automatic logic [NCELL-1:0] m_bomb();
        logic [NCELL-1:0] m = '0;
        foreach (bombs[i])
            if (bombs[i].life > BLAST) m[bombs[i].v * (HMAX + 1) + bombs[i].h] = 1'b1;
        return m;
    endfunction

    function automatic logic [NCELL-1:0] m_blast();
        logic [NCELL-1:0] m = '0;
        for (int y = 0; y <= VMAX; y++)
            for (int x = 0; x <= HMAX; x++)
                foreach (bombs[i])
                    if (bombs[i].life <= BLAST &&
                        ((y == bombs[i].v && x - bombs[i].h <= RAD && bombs[i].h - x <= RAD) ||
                         (x == bombs[i].h && y - bombs[i].v <= RAD && bombs[i].v - y <= RAD)))
                        m[y * (HMAX + 1) + x] = 1'b1;
        return m;
    endfunction

    function automatic int m_count(input int owner);
        int c = 0;
        foreach (bombs[i]) if (bombs[i].owner == owner) c++;
        return c;
    endfunction

    function automatic bit m_hit(input int h, input int v);
        logic [NCELL-1:0] m = m_blast();
        if (h > HMAX || v > VMAX) return 1'b0;
        return m[v * (HMAX + 1) + h];
    endfunction

    function automatic bit accept(input int owner, input int h, input int v, input bomb_t added[$]);
        int cnt = 0;
        if (h > HMAX || v > VMAX) return 1'b0;
        foreach (bombs[i]) begin
            if (bombs[i].h == h && bombs[i].v == v) return 1'b0;
            if (bombs[i].owner == owner) cnt++;
        end
        foreach (added[i]) begin
            if (added[i].h == h && added[i].v == v) return 1'b0;
            if (added[i].owner == owner) cnt++;
        end
        return (cnt < MAXPER) && (bombs.size() + added.size() < NSLOT);
    endfunction

    task automatic model_step();
        bomb_t            nxt[$];
        bomb_t            added[$];
        bomb_t            b;
        bit               chained;
        logic [NCELL-1:0] bl;
        bl = m_blast();
        if (bus.aPlace && accept(0, int'(bus.aH), int'(bus.aV), added))
            added.push_back('{0, int'(bus.aH), int'(bus.aV), FUSE + BLAST});
        if (bus.bPlace && accept(1, int'(bus.bH), int'(bus.bV), added))
            added.push_back('{1, int'(bus.bH), int'(bus.bV), FUSE + BLAST});
        foreach (bombs[i]) begin
            b       = bombs[i];
            chained = 1'b0;
`ifdef BOMB_CHAIN_EN
            chained = (b.life > BLAST) && bl[b.v * (HMAX + 1) + b.h];
`endif
            if (chained)       b.life = BLAST;
            else if (bus.tick) b.life = b.life - 1;
            if (b.life > 0) nxt.push_back(b);
        end
        bombs = {nxt, added};
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("bombMap",  64'(bus.bombMap),  64'(m_bomb()));
            chk("blastMap", 64'(bus.blastMap), 64'(m_blast()));
            chk("aCount",   64'(bus.aCount),   64'(m_count(0)));
            chk("bCount",   64'(bus.bCount),   64'(m_count(1)));
            chk("aHit",     64'(bus.aHit),     64'(m_hit(int'(bus.aH), int'(bus.aV))));
            chk("bHit",     64'(bus.bHit),     64'(m_hit(int'(bus.bH), int'(bus.bV))));
            chk("full",     64'(bus.full),     64'(bombs.size() == NSLOT));
        end
    end

    task automatic cyc(input bit t, input bit ap, input int ah, input int av,
                       input bit bp, input int bh, input int bv);
        bus.tick   = t;
        bus.aPlace = ap;
        bus.aH     = 4'(ah);
        bus.aV     = 4'(av);
        bus.bPlace = bp;
        bus.bH     = 4'(bh);
        bus.bV     = 4'(bv);
        @(posedge clk);
        model_step();
        #1;
        bus.tick   = 1'b0;
        bus.aPlace = 1'b0;
        bus.bPlace = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b1, 1'b0, int'(bus.aH), int'(bus.aV), 1'b0, int'(bus.bH), int'(bus.bV));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bombs.delete();
        bus.tick = 1'b0; bus.aPlace = 1'b0; bus.bPlace = 1'b0;
        bus.aH = 4'd0; bus.aV = 4'd0; bus.bH = 4'd0; bus.bV = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset bombMap",  64'(bus.bombMap),  64'd0);
        chk("reset blastMap", 64'(bus.blastMap), 64'd0);
        chk("reset full",     64'(bus.full),     64'd0);
        rst_n = 1'b1;
    endtask

    function automatic logic [63:0] bit_at(input int i);
        return 64'd1 << i;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        chk_en = 1'b1;
        do_reset();

        // Single placement, fuse, blast, clear
        cyc(0, 1, 2, 1, 0, 0, 0);
        chk("place bombMap", 64'(bus.bombMap), bit_at(12));
        chk("place aCount",  64'(bus.aCount),  64'd1);
        ticks(3);
        chk("fuse end bombMap", 64'(bus.bombMap), 64'd0);
        chk("cross blastMap", 64'(bus.blastMap),
            bit_at(2) | bit_at(11) | bit_at(12) | bit_at(13) | bit_at(22));
        ticks(2);
        chk("blast end blastMap", 64'(bus.blastMap), 64'd0);
        chk("blast end aCount",   64'(bus.aCount),   64'd0);

        // Corner clipping; placement coincides with a tick
        cyc(1, 0, 15, 15, 1, 9, 5);
        ticks(2);
        chk("tick-on-place bombMap", 64'(bus.bombMap), bit_at(59));
        ticks(1);
        chk("corner blastMap", 64'(bus.blastMap), bit_at(49) | bit_at(58) | bit_at(59));
        chk("corner bit50",    64'(bus.blastMap[50]), 64'd0);
        chk("corner bHit",     64'(bus.bHit), 64'd1);
        chk("oor aHit",        64'(bus.aHit), 64'd0);
        ticks(2);

        // Limits: range, per-player cap, full, reuse only from next edge
        cyc(0, 1, 10, 0, 0, 0, 0);
        cyc(0, 1, 0, 6, 0, 0, 0);
        chk("out of range aCount", 64'(bus.aCount), 64'd0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0);
        cyc(0, 1, 2, 0, 0, 0, 0);
        chk("cap aCount",  64'(bus.aCount),  64'd2);
        chk("cap bombMap", 64'(bus.bombMap), 64'h3);
        cyc(0, 0, 0, 0, 1, 3, 0);
        cyc(0, 0, 0, 0, 1, 4, 0);
        chk("full flag", 64'(bus.full), 64'd1);
        cyc(0, 0, 0, 0, 1, 5, 0);
        chk("full bCount",  64'(bus.bCount),  64'd2);
        chk("full bombMap", 64'(bus.bombMap), 64'h1B);
        ticks(4);
        cyc(1, 1, 6, 0, 0, 0, 0);
        chk("reuse same edge aCount", 64'(bus.aCount), 64'd0);
        chk("reuse same edge full",   64'(bus.full),   64'd0);

        // Contention
        cyc(0, 1, 5, 3, 1, 5, 3);
        chk("contend aCount",  64'(bus.aCount),  64'd1);
        chk("contend bCount",  64'(bus.bCount),  64'd0);
        chk("contend bombMap", 64'(bus.bombMap), bit_at(35));
        cyc(0, 0, 0, 0, 1, 5, 3);
        chk("occupied bCount", 64'(bus.bCount), 64'd0);
        cyc(0, 1, 7, 4, 1, 8, 4);
        chk("dual aCount", 64'(bus.aCount), 64'd2);
        chk("dual bCount", 64'(bus.bCount), 64'd1);
        ticks(5);

        // Hit, then asynchronous reset between edges
        cyc(0, 1, 4, 2, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 4, 3, 0, 0, 0);
        chk("aHit", 64'(bus.aHit), 64'd1);
        chk("bHit", 64'(bus.bHit), 64'd0);
        #2;
        rst_n = 1'b0;
        bombs.delete();
        #1;
        chk("async blastMap", 64'(bus.blastMap), 64'd0);
        chk("async aHit",     64'(bus.aHit),     64'd0);
        chk("async aCount",   64'(bus.aCount),   64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Chain behaviour
        cyc(0, 1, 1, 1, 0, 0, 0);
        ticks(2);
        cyc(0, 1, 2, 1, 0, 0, 0);
        ticks(1);
        chk("chain first blast", 64'(bus.blastMap[12]), 64'd1);
        cyc(0, 0, 0, 0, 0, 0, 0);
`ifdef BOMB_CHAIN_EN
        chk("chain second bombMap", 64'(bus.bombMap), 64'd0);
`else
        chk("no chain second bombMap", 64'(bus.bombMap), bit_at(12));
`endif
        ticks(5);
        chk("final aCount", 64'(bus.aCount), 64'd0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
